ula_issue_stage: RTL and testbench
==================================

// Module: ula_issue_stage
// PURPOSE
//  Buffered issue/retire stage wrapped around the 32-bit ULA (AND/OR/ADD/SUB/SLT).
//  Accepts ALU commands (a, b, f, tag) on a valid/ready port into a DEPTH-entry FIFO.
//  Drives the FIFO head onto the ULA operand/control inputs, then registers the ULA
//  result (y, zero, tag) into a one-entry output register with its own valid/ready.
//  The ULA stays a separate combinational instance: this block feeds and consumes it.
// PARAMETERS
//  DEPTH   4   command FIFO entries; power of 2, >= 2
//  TAGW    4   width of the opaque command tag carried through to the result
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      FIFO can accept (= !full)
//  cmd_a      in   32     operand a
//  cmd_b      in   32     operand b
//  cmd_f      in   3      ULA function (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
//  cmd_tag    in   TAGW   returned unchanged with the result
//  ula_a      out  32     to ULA a  (FIFO head; 0 when empty)
//  ula_b      out  32     to ULA b  (FIFO head; 0 when empty)
//  ula_f      out  3      to ULA f  (FIFO head; 0 when empty)
//  ula_y      in   32     from ULA y
//  ula_zero   in   1      from ULA zero
//  res_valid  out  1      result register holds a result
//  res_ready  in   1      consumer takes result
//  res_y      out  32     registered result
//  res_zero   out  1      registered zero flag
//  res_tag    out  TAGW   tag of that result
//  flush      in   1      synchronous clear of FIFO and result register
//  count      out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (reset_n=0, async): wr/rd pointers=0, count=0, res_valid=0, res_y=0,
//   res_zero=0, res_tag=0. cmd_ready=1 and ula_*=0 immediately after release.
//  Push: cmd_valid & cmd_ready at a clk edge writes {a,b,f,tag} at wr_ptr; wr_ptr++ mod DEPTH.
//  cmd_ready = (count != DEPTH). No combinational path from res_ready to cmd_ready.
//  Pop/capture: fire = (count != 0) & (!res_valid | res_ready). On fire: load res_y<=ula_y,
//   res_zero<=ula_zero, res_tag<=head tag, res_valid<=1; rd_ptr++ mod DEPTH.
//  Drain without fire: res_valid & res_ready & count==0 -> res_valid<=0 (data regs hold).
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  Latency: command accepted at edge k into empty FIFO with free output -> res_valid high
//   after edge k+1 (2 cycles). Throughput 1 result/cycle with res_ready held 1.
//  Capacity under full backpressure: DEPTH in FIFO + 1 in result register.
//  Ordering: strict FIFO; results leave in command order.
//  Arithmetic (overflow, SLT sign) is the ULA's; this stage never alters y/zero.
//   Unlisted f codes are passed through unchanged.
//  res_* stable while res_valid & !res_ready.
//  flush (sync) has priority over everything: pointers=0, count=0, res_valid=0;
//   a push or fire in the flush cycle is discarded.
//  Async reset mid-transfer discards all entries; no partial result is emitted.
// TESTING
//  1 reset: 3 queued, reset_n=0 mid-cycle -> count=0, res_valid=0, cmd_ready=1, ula_a=0 at once.
//  2 add: a=5,b=7,f=010,tag=1 -> 2 cycles later res_valid=1, res_y=12, res_zero=0, res_tag=1.
//  3 sub/slt: a=b=0x1234,f=110 -> res_y=0,res_zero=1; a=0xFFFFFFFF,b=1,f=111 -> res_y=1.
//  4 backpressure: res_ready=0, push tags 0..DEPTH -> DEPTH+1 accepted, cmd_ready=0, count=DEPTH;
//    res_ready=1 -> tags 0..DEPTH out in order, one per cycle.
//  5 streaming: 200 random back-to-back cmds, res_ready=1 -> 1 result/cycle, matches model,
//    count stays 1.
//  6 flush: 2 queued + push in flush cycle -> count=0, res_valid=0, pushed cmd never appears.

Source files
------------

// File: rtl/ula_issue_stage.sv
// Buffered issue/retire stage around an external combinational 32-bit ULA.
// Commands queue in a DEPTH-entry FIFO; the head feeds the ULA and its result is held in a one-entry output register.
module ula_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [2:0]             cmd_f,
  input  logic [TAGW-1:0]        cmd_tag,
  output logic [31:0]            ula_a,
  output logic [31:0]            ula_b,
  output logic [2:0]             ula_f,
  input  logic [31:0]            ula_y,
  input  logic                   ula_zero,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_y,
  output logic                   res_zero,
  output logic [TAGW-1:0]        res_tag,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [31:0]     mem_a   [DEPTH];
  logic [31:0]     mem_b   [DEPTH];
  logic [2:0]      mem_f   [DEPTH];
  logic [TAGW-1:0] mem_tag [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          not_empty;
  logic          push;
  logic          fire;

  // cmd_ready depends only on occupancy, so res_ready never reaches it combinationally.
  assign not_empty = (count != '0);
  assign cmd_ready = (count != FULL_COUNT);
  assign push      = cmd_valid & cmd_ready & ~flush;
  assign fire      = not_empty & (~res_valid | res_ready) & ~flush;

  assign ula_a = not_empty ? mem_a[rd_ptr] : 32'd0;
  assign ula_b = not_empty ? mem_b[rd_ptr] : 32'd0;
  assign ula_f = not_empty ? mem_f[rd_ptr] : 3'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= cmd_a;
      mem_b[wr_ptr]   <= cmd_b;
      mem_f[wr_ptr]   <= cmd_f;
      mem_tag[wr_ptr] <= cmd_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (fire) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_y     <= 32'd0;
      res_zero  <= 1'b0;
      res_tag   <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (fire) begin
      res_valid <= 1'b1;
      res_y     <= ula_y;
      res_zero  <= ula_zero;
      res_tag   <= mem_tag[rd_ptr];
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ula_issue_stage.sv
// Randomized self-checking bench for ula_issue_stage with a queue-based reference model.
// The bench also plays the external ULA so results flow through the real datapath.
module tb_ula_issue_stage;

  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk;
  logic            reset_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [31:0]     cmd_a;
  logic [31:0]     cmd_b;
  logic [2:0]      cmd_f;
  logic [TAGW-1:0] cmd_tag;
  logic [31:0]     ula_a;
  logic [31:0]     ula_b;
  logic [2:0]      ula_f;
  logic [31:0]     ula_y;
  logic            ula_zero;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_y;
  logic            res_zero;
  logic [TAGW-1:0] res_tag;
  logic            flush;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]     a;
    logic [31:0]     b;
    logic [2:0]      f;
    logic [TAGW-1:0] tag;
  } cmd_t;

  cmd_t            mq[$];
  logic            m_valid;
  logic [31:0]     m_y;
  logic            m_zero;
  logic [TAGW-1:0] m_tag;

  ula_issue_stage #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_f(cmd_f), .cmd_tag(cmd_tag),
    .ula_a(ula_a), .ula_b(ula_b), .ula_f(ula_f),
    .ula_y(ula_y), .ula_zero(ula_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_zero(res_zero), .res_tag(res_tag),
    .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ula_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic [31:0] bb;
    logic [31:0] s;
    bb = f[2] ? ~b : b;
    s  = a + bb + {31'd0, f[2]};
    case (f[1:0])
      2'b00:   return a & bb;
      2'b01:   return a | bb;
      2'b10:   return s;
      default: return {31'd0, s[31]};
    endcase
  endfunction

  always_comb begin
    ula_y    = ula_fn(ula_a, ula_b, ula_f);
    ula_zero = (ula_y == 32'd0);
  end

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", name, observed, expected, $time);
    end
  endtask

  task automatic modelClear();
    mq.delete();
    m_valid = 1'b0;
    m_y     = 32'd0;
    m_zero  = 1'b0;
    m_tag   = '0;
  endtask

  // One clock edge of the reference: pop into the result slot, then enqueue.
  task automatic modelEdge();
    cmd_t c;
    int   sz;
    bit   fire_m;
    bit   push_m;
    sz = mq.size();
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
      return;
    end
    fire_m = (sz != 0) && (!m_valid || res_ready);
    push_m = cmd_valid && (sz < DEPTH);
    if (fire_m) begin
      c       = mq.pop_front();
      m_y     = ula_fn(c.a, c.b, c.f);
      m_zero  = (m_y == 32'd0);
      m_tag   = c.tag;
      m_valid = 1'b1;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    if (push_m) begin
      c.a = cmd_a; c.b = cmd_b; c.f = cmd_f; c.tag = cmd_tag;
      mq.push_back(c);
    end
  endtask

  task automatic compareModel();
    checkOutput("count", 64'(count), 64'(mq.size()));
    checkOutput("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
    checkOutput("res_valid", 64'(res_valid), 64'(m_valid));
    if (m_valid) begin
      checkOutput("res_y", 64'(res_y), 64'(m_y));
      checkOutput("res_zero", 64'(res_zero), 64'(m_zero));
      checkOutput("res_tag", 64'(res_tag), 64'(m_tag));
    end
    if (mq.size() != 0) begin
      checkOutput("ula_a", 64'(ula_a), 64'(mq[0].a));
      checkOutput("ula_b", 64'(ula_b), 64'(mq[0].b));
      checkOutput("ula_f", 64'(ula_f), 64'(mq[0].f));
    end else begin
      checkOutput("ula_a_idle", 64'(ula_a), 64'd0);
    end
  endtask

  // Drive one cycle of inputs, take the edge, and compare against the model.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] f, input logic [TAGW-1:0] tag,
                               input logic rr, input logic fl);
    cmd_valid = v; cmd_a = a; cmd_b = b; cmd_f = f; cmd_tag = tag;
    res_ready = rr; flush = fl;
    @(posedge clk);
    modelEdge();
    #1;
    compareModel();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_f = 0; cmd_tag = 0;
    res_ready = 0; flush = 0;
    reset_n = 1'b0;
    modelClear();
    #12;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_res_y", 64'(res_y), 64'd0);
    checkOutput("rst_res_tag", 64'(res_tag), 64'd0);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    reset_n = 1'b1;

    $display("[TB] async reset with entries queued");
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'(i + 9), 32'd3, 3'b010, TAGW'(i), 0, 0);
    checkOutput("pre_rst_count", 64'(count), 64'd2);
    #3 reset_n = 1'b0;
    modelClear();
    #1;
    checkOutput("mid_rst_count", 64'(count), 64'd0);
    checkOutput("mid_rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("mid_rst_ula_a", 64'(ula_a), 64'd0);
    checkOutput("mid_rst_res_y", 64'(res_y), 64'd0);
    cmd_valid = 0;
    @(posedge clk);
    #2 reset_n = 1'b1;

    $display("[TB] add latency");
    applyStimulus(1, 32'd5, 32'd7, 3'b010, 4'd1, 1, 0);
    checkOutput("add_edge_k_valid", 64'(res_valid), 64'd0);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 4'd0, 1, 0);
    checkOutput("add_valid", 64'(res_valid), 64'd1);
    checkOutput("add_y", 64'(res_y), 64'd12);
    checkOutput("add_zero", 64'(res_zero), 64'd0);
    checkOutput("add_tag", 64'(res_tag), 64'd1);

    $display("[TB] sub and slt");
    applyStimulus(1, 32'h1234, 32'h1234, 3'b110, 4'd2, 1, 0);
    applyStimulus(1, 32'hFFFF_FFFF, 32'd1, 3'b111, 4'd3, 1, 0);
    checkOutput("sub_y", 64'(res_y), 64'd0);
    checkOutput("sub_zero", 64'(res_zero), 64'd1);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 4'd0, 1, 0);
    checkOutput("slt_y", 64'(res_y), 64'd1);
    checkOutput("slt_tag", 64'(res_tag), 64'd3);
    applyStimulus(0, 32'd0, 32'd0, 3'b000, 4'd0, 1, 0);

    $display("[TB] backpressure");
    for (int i = 0; i <= DEPTH + 1; i++)
      applyStimulus(1, 32'(i * 3), 32'(i), 3'b010, TAGW'(i), 0, 0);
    checkOutput("bp_count", 64'(count), 64'(DEPTH));
    checkOutput("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("bp_head_tag", 64'(res_tag), 64'd0);
    res_ready = 1'b1; cmd_valid = 1'b0;
    #1;
    for (int i = 0; i <= DEPTH; i++) begin
      checkOutput("bp_out_valid", 64'(res_valid), 64'd1);
      checkOutput("bp_out_tag", 64'(res_tag), 64'(i));
      applyStimulus(0, 32'd0, 32'd0, 3'b000, 4'd0, 1, 0);
    end
    checkOutput("bp_drained", 64'(res_valid), 64'd0);

    $display("[TB] streaming");
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      applyStimulus(1, ra, rb, 3'($urandom_range(0, 7)), TAGW'(i), 1, 0);
      if (i >= 1) begin
        checkOutput("stream_count", 64'(count), 64'd1);
        checkOutput("stream_valid", 64'(res_valid), 64'd1);
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'd0, 32'd0, 3'b000, 4'd0, 1, 0);

    $display("[TB] flush");
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'(i + 1), 32'd1, 3'b010, TAGW'(i + 4), 0, 0);
    applyStimulus(1, 32'd77, 32'd1, 3'b010, 4'hC, 0, 1);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_res_valid", 64'(res_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'd0, 32'd0, 3'b000, 4'd0, 1, 0);
      checkOutput("flush_no_ghost", 64'(res_valid), 64'd0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      applyStimulus(($urandom_range(0, 3) != 0), ra, rb, 3'($urandom_range(0, 7)), TAGW'($urandom),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
